com_to_fifo: RTL and testbench
==============================

# com_to_fifo

Serial receive path for the board's UART link: the mirror of the switch→FIFO→tx chain. It samples the incoming `rx` line with a 2-flop synchronizer and an oversampling bit timer, deserialises 8N1 frames (optional even parity), and checks stop and parity. Each good byte is pushed into the shared `FIFO` through the same `fifo_we`/`fifo_busy` handshake the transmit side uses. It keeps a running CRC-8 of accepted bytes and a saturating error count for the seven-segment display.

## Interface
- `OS`, 16: clk cycles per bit; even, ≥4.
- `PARITY_EN`, 0: 1 = a parity bit follows the data and must make total ones even.
- `clk` input 1: sampling clock, OS× the baud rate.
- `reset` input 1: synchronous, active-high; clears all state.
- `enable` input 1: 1 = receive; 0 = abort/hold the frame FSM in IDLE.
- `rx` input 1: asynchronous serial line, idle high.
- `fifo_busy` input 1: FIFO cannot accept a write this cycle.
- `fifo_full` input 1: FIFO full.
- `fifo_we` output 1: one-cycle write strobe.
- `fifo_data` output 8: byte to write; valid while `fifo_we`=1.
- `isFinish` output 1: one-cycle pulse, coincident with `fifo_we`.
- `CRC` output 8: CRC-8 (poly 0x07, init 0x00, MSB-first) over every byte written to the FIFO.
- `error` output 4: saturating count (max 15) of frame, parity and overrun events.
- `err_flags` output 3: {overrun, parity, frame}; one-cycle pulse per event.

## Operation
- Reset values: `fifo_we`=0, `isFinish`=0, `fifo_data`=0x00, `CRC`=0x00, `error`=0, `err_flags`=0. Both synchronizer flops=1, FSM=IDLE, pending=0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: the first cycle with synchronized `rx_s`=0 is cycle t0. Go to START and load the bit timer.
- START: sample at t0+OS/2.
  - `rx_s`=1: false start, return to IDLE, no flag raised.
  - Otherwise go to DATA.
- DATA: sample bit i (LSB first, i=0..7) at t0+OS/2+(i+1)·OS and shift it in.
- PARITY (only when PARITY_EN=1): sample at t0+OS/2+9·OS.
- STOP: sample at t0+OS/2+(9+P)·OS, where P=PARITY_EN.
  - `rx_s`=0: frame error. Discard the byte and go to WAIT_IDLE, which waits for `rx_s`=1 before IDLE.
  - `rx_s`=1 and parity bad: parity error, discard the byte, go to IDLE.
  - Otherwise the byte goes to the 1-entry pending register and the FSM returns to IDLE.
- Push: while pending=1, `!fifo_busy` and `!fifo_full`, assert `fifo_we` and `isFinish` for one cycle and clear pending. In that same cycle, update `CRC` with `fifo_data`.
- Overrun, case 1: a new good byte completes while pending=1. Drop the new byte, keep the old one, pulse overrun.
- Overrun, case 2: pending=1 and `fifo_full`=1 at the stop sample of the next frame. Handled the same way as case 1.
- Error events each increment `error` by 1, saturating at 15. At most one flag per frame; priority frame > parity > overrun.
- `enable`=0:
  - FSM is forced to IDLE and any partial frame is lost silently.
  - The pending byte is still pushed and CRC still updated.
  - Reception resumes on the next falling edge after `enable` returns to 1.
- `reset` mid-frame or mid-push: everything returns to reset values the next cycle, with no write issued.

## Timing
- Synchronizer delay is 2 cycles from the `rx` pin to `rx_s`.
- The write happens at stop-sample cycle +1 if the FIFO is ready; otherwise it waits until `fifo_busy`=0 and `fifo_full`=0.
- `fifo_data` is stable from the cycle before `fifo_we` through the `fifo_we` cycle.
- The new `CRC` is visible the cycle after `fifo_we`. `error` updates the cycle after the flag pulse.
- Back-to-back frames: a start edge may be detected in the cycle after the stop sample. One stop bit is sufficient.
- A frame error holds WAIT_IDLE until at least one cycle of `rx_s`=1; a line held at 0 (break) produces exactly one frame error.

## Test plan
- OS=4, PARITY_EN=0; send 0xA5 with `fifo_busy`=0 → one `fifo_we` with `fifo_data`=0xA5 at stop+1; `CRC`=0x72; `error`=0.
- Send 0x31 then 0x32 back-to-back → two writes in order; `CRC`=CRC8(0x31,0x32); no flags.
- Send 0x55 with stop bit forced low, then line held low for 10 bits → one frame pulse, `error`=1, no write, next good byte 0x01 is accepted.
- PARITY_EN=1; send 0x03 with parity bit=1 → parity pulse, no write. Resend with parity=0 → write of 0x03.
- Hold `fifo_busy`=1; send 0x11 then 0x22 → overrun pulse on 0x22. Release busy → single write of 0x11; `error`=1.
- Assert `reset` in DATA of 0xFF → outputs at reset values next cycle, no write. A 2-cycle low glitch on `rx` → no frame started, no flags.

Source files
------------

// File: rtl/com_to_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : com_to_fifo_if
// Brief    : Write-side handshake between the serial receiver and the FIFO.
// Revision : 1.0
// ============================================================================
interface com_to_fifo_if;
    logic       fifo_we;
    logic [7:0] fifo_data;
    logic       fifo_busy;
    logic       fifo_full;

    modport master (
        output fifo_we,
        output fifo_data,
        input  fifo_busy,
        input  fifo_full
    );

    modport slave (
        input  fifo_we,
        input  fifo_data,
        output fifo_busy,
        output fifo_full
    );
endinterface
`default_nettype wire

// File: rtl/com_to_fifo.sv
`default_nettype none
// ============================================================================
// Module   : com_to_fifo
// Brief    : UART 8N1 receiver (optional even parity) pushing good bytes into
//            the shared FIFO; running CRC-8 and saturating error counter.
// Revision : 1.0
// ============================================================================
module com_to_fifo #(
    parameter int OS        = 16,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx,
    com_to_fifo_if.master        fifo,
    output logic                 isFinish,
    output logic [7:0]           CRC,
    output logic [3:0]           error,
    output logic [2:0]           err_flags
);

    localparam int                c_tw   = $clog2(OS);
    localparam logic [c_tw-1:0]   c_half = c_tw'(OS / 2 - 1);
    localparam logic [c_tw-1:0]   c_full = c_tw'(OS - 1);
    localparam logic [c_tw-1:0]   c_one  = c_tw'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t            state_q,     state_d;
    logic              sync1_q,     sync1_d;
    logic              rx_s_q,      rx_s_d;
    logic              rx_prev_q,   rx_prev_d;
    logic [c_tw-1:0]   timer_q,     timer_d;
    logic [2:0]        bit_cnt_q,   bit_cnt_d;
    logic [7:0]        shift_q,     shift_d;
    logic              par_q,       par_d;
    logic              pending_q,   pending_d;
    logic [7:0]        fifo_data_q, fifo_data_d;
    logic [7:0]        crc_q,       crc_d;
    logic [3:0]        error_q,     error_d;
    logic [2:0]        err_flags_q, err_flags_d;

    logic              w_push;
    logic              w_tick;
    logic              w_par_bad;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign w_push    = pending_q & ~fifo.fifo_busy & ~fifo.fifo_full;
    assign w_tick    = (timer_q == '0);
    assign w_par_bad = PARITY_EN & ((^shift_q) ^ par_q);

    always_comb begin
        sync1_d     = rx;
        rx_s_d      = sync1_q;
        rx_prev_d   = rx_s_q;
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        pending_d   = pending_q;
        crc_d       = crc_q;
        err_flags_d = 3'b000;
        error_d     = error_q;
        // Track the shift register while nothing is pending, so the byte is
        // already on fifo_data well before the stop sample commits it.
        fifo_data_d = pending_q ? fifo_data_q : shift_q;

        if ((err_flags_q != 3'b000) && (error_q != 4'hF)) begin
            error_d = error_q + 4'd1;
        end

        if (w_push) begin
            pending_d = 1'b0;
            crc_d     = crc8_next(crc_q, fifo_data_q);
        end

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q && rx_prev_q) begin
                        state_d = S_START;
                        timer_d = c_half;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            timer_d   = c_full;
                            bit_cnt_d = 3'd0;
                        end
                    end else begin
                        timer_d = timer_q - c_one;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        timer_d   = c_full;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = PARITY_EN ? S_PARITY : S_STOP;
                        end
                    end else begin
                        timer_d = timer_q - c_one;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        par_d   = rx_s_q;
                        timer_d = c_full;
                        state_d = S_STOP;
                    end else begin
                        timer_d = timer_q - c_one;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (!rx_s_q) begin
                            err_flags_d = 3'b001;
                            state_d     = S_WAIT_IDLE;
                        end else begin
                            state_d = S_IDLE;
                            if (w_par_bad) begin
                                err_flags_d = 3'b010;
                            end else if (pending_q) begin
                                err_flags_d = 3'b100;
                            end else begin
                                pending_d = 1'b1;
                            end
                        end
                    end else begin
                        timer_d = timer_q - c_one;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            timer_q     <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            pending_q   <= 1'b0;
            fifo_data_q <= 8'h00;
            crc_q       <= 8'h00;
            error_q     <= 4'h0;
            err_flags_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            pending_q   <= pending_d;
            fifo_data_q <= fifo_data_d;
            crc_q       <= crc_d;
            error_q     <= error_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign fifo.fifo_we   = w_push;
    assign fifo.fifo_data = fifo_data_q;
    assign isFinish       = w_push;
    assign CRC            = crc_q;
    assign error          = error_q;
    assign err_flags      = err_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_com_to_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_com_to_fifo
// Brief    : Self-checking bench: directed frames plus random traffic against
//            a frame-level reference model (one 8N1 and one 8E1 instance).
// Revision : 1.0
// ============================================================================
module tb_com_to_fifo;
    localparam int OS = 4;

    logic clk = 1'b0;
    logic reset, enable, rx0, rx1;
    logic isf0, isf1;
    logic [7:0] crc0, crc1;
    logic [3:0] err0, err1;
    logic [2:0] flg0, flg1;

    always #5 clk = ~clk;

    com_to_fifo_if f0 ();
    com_to_fifo_if f1 ();

    com_to_fifo #(.OS(OS), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx0), .fifo(f0),
        .isFinish(isf0), .CRC(crc0), .error(err0), .err_flags(flg0));

    com_to_fifo #(.OS(OS), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx1), .fifo(f1),
        .isFinish(isf1), .CRC(crc1), .error(err1), .err_flags(flg1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed traffic, collected away from the active edge
    logic [7:0] act_d0[$];
    logic [7:0] act_d1[$];
    int         act_t0[$];
    int         fr_c[2], pa_c[2], ov_c[2];
    int         fin_bad = 0, multi_bad = 0, stab_bad = 0;
    logic [7:0] prev_d0 = 8'h00;

    initial begin
        for (int i = 0; i < 2; i++) begin
            fr_c[i] = 0; pa_c[i] = 0; ov_c[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (f0.fifo_we === 1'b1) begin
            act_d0.push_back(f0.fifo_data);
            act_t0.push_back(cyc);
            if (f0.fifo_data !== prev_d0) stab_bad++;
        end
        if (f1.fifo_we === 1'b1) act_d1.push_back(f1.fifo_data);
        prev_d0 = f0.fifo_data;
        if (isf0 !== f0.fifo_we || isf1 !== f1.fifo_we) fin_bad++;
        if ($countones(flg0) > 1 || $countones(flg1) > 1) multi_bad++;
        fr_c[0] += int'(flg0[0]); pa_c[0] += int'(flg0[1]); ov_c[0] += int'(flg0[2]);
        fr_c[1] += int'(flg1[0]); pa_c[1] += int'(flg1[1]); ov_c[1] += int'(flg1[2]);
    end

    // Frame-level reference model
    logic       m_pend[2];
    logic [7:0] m_pb[2];
    logic [7:0] m_crc[2];
    int         m_err[2], m_fr[2], m_pa[2], m_ov[2];
    logic [7:0] exp_d0[$];
    logic [7:0] exp_d1[$];
    int         rd0 = 0, rd1 = 0;
    int         n_checks = 0, n_pass = 0, n_fail = 0;

    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_event(input int w);
        if (m_err[w] < 15) m_err[w]++;
    endtask

    task automatic model_frame(input int w, input logic [7:0] d, input logic stop_v, input logic par_v);
        if (!stop_v) begin
            m_fr[w]++; model_event(w);
        end else if (w == 1 && ((^d) ^ par_v)) begin
            m_pa[w]++; model_event(w);
        end else if (m_pend[w]) begin
            m_ov[w]++; model_event(w);
        end else begin
            m_pend[w] = 1'b1; m_pb[w] = d;
        end
    endtask

    task automatic model_drain(input int w);
        if (m_pend[w]) begin
            if (w == 0) exp_d0.push_back(m_pb[w]); else exp_d1.push_back(m_pb[w]);
            m_crc[w]  = ref_crc(m_crc[w], m_pb[w]);
            m_pend[w] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_pend[w] = 1'b0; m_crc[w] = 8'h00; m_err[w] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic drive_bit(input int w, input logic v);
        tick();
        set_rx(w, v);
        repeat (OS - 1) tick();
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input logic stop_v,
                              input logic par_v, output int t_start);
        tick();
        set_rx(w, 1'b0);
        t_start = cyc;
        repeat (OS - 1) tick();
        for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
        if (w == 1) drive_bit(w, par_v);
        drive_bit(w, stop_v);
    endtask

    task automatic partial_frame(input int w, input int nbits);
        drive_bit(w, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(w, 1'b1);
    endtask

    task automatic idle(input int w, input int n);
        tick();
        set_rx(w, 1'b1);
        repeat (n - 1) tick();
    endtask

    task automatic compare_writes(input int w, input string tag);
        if (w == 0) begin
            check({tag, "_wcount"}, 32'(act_d0.size()), 32'(exp_d0.size()));
            for (int i = rd0; i < act_d0.size() && i < exp_d0.size(); i++)
                check({tag, "_wdata"}, 32'(act_d0[i]), 32'(exp_d0[i]));
            rd0 = act_d0.size();
        end else begin
            check({tag, "_wcount"}, 32'(act_d1.size()), 32'(exp_d1.size()));
            for (int i = rd1; i < act_d1.size() && i < exp_d1.size(); i++)
                check({tag, "_wdata"}, 32'(act_d1[i]), 32'(exp_d1[i]));
            rd1 = act_d1.size();
        end
    endtask

    task automatic check_state(input int w, input string tag);
        check({tag, "_crc"},   32'(w == 0 ? crc0 : crc1), 32'(m_crc[w]));
        check({tag, "_error"}, 32'(w == 0 ? err0 : err1), 32'(m_err[w]));
        check({tag, "_frame"}, 32'(fr_c[w]), 32'(m_fr[w]));
        check({tag, "_par"},   32'(pa_c[w]), 32'(m_pa[w]));
        check({tag, "_ovr"},   32'(ov_c[w]), 32'(m_ov[w]));
    endtask

    initial begin
        int         t;
        int         nf, blk, gap;
        logic [7:0] d;
        logic       sv;

        for (int w = 0; w < 2; w++) begin
            m_fr[w] = 0; m_pa[w] = 0; m_ov[w] = 0;
        end
        model_reset();
        reset = 1'b1; enable = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        f0.fifo_busy = 1'b0; f0.fifo_full = 1'b0;
        f1.fifo_busy = 1'b0; f1.fifo_full = 1'b0;
        repeat (3) tick();

        check("rst_we",    32'(f0.fifo_we),   32'd0);
        check("rst_fin",   32'(isf0),         32'd0);
        check("rst_data",  32'(f0.fifo_data), 32'h00);
        check("rst_crc",   32'(crc0),         32'h00);
        check("rst_error", 32'(err0),         32'd0);
        check("rst_flags", 32'(flg0),         32'd0);
        reset = 1'b0;
        idle(0, 2 * OS);

        // Single byte: write timing, known CRC value
        send_frame(0, 8'hA5, 1'b1, 1'b0, t);
        model_frame(0, 8'hA5, 1'b1, 1'b0); model_drain(0);
        idle(0, 2 * OS);
        compare_writes(0, "a5");
        check("a5_time", 32'(act_t0[0]), 32'(t + 3 + OS / 2 + 9 * OS));
        check("a5_crc_const", 32'(crc0), 32'h72);
        check_state(0, "a5");

        // Back-to-back frames
        send_frame(0, 8'h31, 1'b1, 1'b0, t);
        send_frame(0, 8'h32, 1'b1, 1'b0, t);
        model_frame(0, 8'h31, 1'b1, 1'b0); model_drain(0);
        model_frame(0, 8'h32, 1'b1, 1'b0); model_drain(0);
        idle(0, 2 * OS);
        compare_writes(0, "b2b");
        check_state(0, "b2b");

        // Frame error followed by a break, then recovery
        send_frame(0, 8'h55, 1'b0, 1'b0, t);
        repeat (10 * OS) tick();
        idle(0, 2 * OS);
        send_frame(0, 8'h01, 1'b1, 1'b0, t);
        model_frame(0, 8'h55, 1'b0, 1'b0);
        model_frame(0, 8'h01, 1'b1, 1'b0); model_drain(0);
        idle(0, 2 * OS);
        compare_writes(0, "brk");
        check_state(0, "brk");

        // Even parity on the second instance
        send_frame(1, 8'h03, 1'b1, 1'b1, t);
        model_frame(1, 8'h03, 1'b1, 1'b1);
        idle(1, 2 * OS);
        send_frame(1, 8'h03, 1'b1, 1'b0, t);
        model_frame(1, 8'h03, 1'b1, 1'b0); model_drain(1);
        idle(1, 2 * OS);
        compare_writes(1, "par");
        check_state(1, "par");

        // Overrun with busy, then with full
        f0.fifo_busy = 1'b1;
        send_frame(0, 8'h11, 1'b1, 1'b0, t);
        send_frame(0, 8'h22, 1'b1, 1'b0, t);
        model_frame(0, 8'h11, 1'b1, 1'b0);
        model_frame(0, 8'h22, 1'b1, 1'b0);
        idle(0, 2 * OS);
        compare_writes(0, "ovr_held");
        f0.fifo_busy = 1'b0;
        model_drain(0);
        idle(0, 2 * OS);
        compare_writes(0, "ovr");
        check_state(0, "ovr");
        f0.fifo_full = 1'b1;
        send_frame(0, 8'h44, 1'b1, 1'b0, t);
        send_frame(0, 8'h45, 1'b1, 1'b0, t);
        model_frame(0, 8'h44, 1'b1, 1'b0);
        model_frame(0, 8'h45, 1'b1, 1'b0);
        idle(0, 2 * OS);
        f0.fifo_full = 1'b0;
        model_drain(0);
        idle(0, 2 * OS);
        compare_writes(0, "full");
        check_state(0, "full");

        // Enable low aborts the frame but still drains the pending byte
        f0.fifo_busy = 1'b1;
        send_frame(0, 8'h66, 1'b1, 1'b0, t);
        model_frame(0, 8'h66, 1'b1, 1'b0);
        partial_frame(0, 3);
        enable = 1'b0;
        repeat (OS) tick();
        f0.fifo_busy = 1'b0;
        model_drain(0);
        repeat (3 * OS) tick();
        enable = 1'b1;
        idle(0, 2 * OS);
        send_frame(0, 8'h42, 1'b1, 1'b0, t);
        model_frame(0, 8'h42, 1'b1, 1'b0); model_drain(0);
        idle(0, 2 * OS);
        compare_writes(0, "ena");
        check_state(0, "ena");

        // Error counter saturation
        for (int i = 0; i < 16; i++) begin
            send_frame(1, 8'h01, 1'b1, 1'b0, t);
            model_frame(1, 8'h01, 1'b1, 1'b0);
            idle(1, OS);
        end
        idle(1, 2 * OS);
        check("sat_error", 32'(err1), 32'd15);
        check_state(1, "sat");

        // Reset in DATA with a byte still pending
        f0.fifo_busy = 1'b1;
        send_frame(0, 8'h5A, 1'b1, 1'b0, t);
        model_frame(0, 8'h5A, 1'b1, 1'b0);
        idle(0, 2 * OS);
        partial_frame(0, 3);
        reset = 1'b1;
        tick();
        check("mrst_we",    32'(f0.fifo_we),   32'd0);
        check("mrst_data",  32'(f0.fifo_data), 32'h00);
        check("mrst_crc",   32'(crc0),         32'h00);
        check("mrst_error", 32'(err0),         32'd0);
        check("mrst_flags", 32'(flg0),         32'd0);
        reset = 1'b0;
        f0.fifo_busy = 1'b0;
        model_reset();
        idle(0, 3 * OS);
        compare_writes(0, "mrst");

        // Two-cycle glitch must not start a frame
        tick(); rx0 = 1'b0;
        tick(); tick(); rx0 = 1'b1;
        idle(0, 3 * OS);
        compare_writes(0, "glitch");
        check_state(0, "glitch");

        // Random traffic with random back-pressure
        for (int it = 0; it < 24; it++) begin
            nf  = $urandom_range(1, 2);
            blk = $urandom_range(0, 2);
            f0.fifo_busy = (blk == 1);
            f0.fifo_full = (blk == 2);
            for (int f = 0; f < nf; f++) begin
                d  = 8'($urandom);
                sv = ($urandom_range(0, 5) != 0);
                send_frame(0, d, sv, 1'b0, t);
                model_frame(0, d, sv, 1'b0);
                if (blk == 0) model_drain(0);
                gap = sv ? $urandom_range(0, 3) : $urandom_range(1, 3);
                if (gap > 0) idle(0, gap);
            end
            idle(0, 2 * OS);
            f0.fifo_busy = 1'b0;
            f0.fifo_full = 1'b0;
            model_drain(0);
            idle(0, 2 * OS);
        end
        compare_writes(0, "rand");
        check_state(0, "rand");

        check("fin_coincident", 32'(fin_bad),   32'd0);
        check("one_flag",       32'(multi_bad), 32'd0);
        check("data_stable",    32'(stab_bad),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
